jtsdram_resp: RTL and testbench
===============================

# jtsdram_resp

Synthesizable SDRAM-controller stand-in that answers the request side of the JTSDRAM bank ports: one programming port and four bank ports (bank 0 read/write, banks 1-3 read-only). It arbitrates requests, models fixed access latency and refresh blocking, and serves data from internal block RAM. It sits opposite the checker in simulation and in small-FPGA self-test builds, so the checker can be exercised without a real SDRAM controller.

## Interface
- AW, 10: word-address bits stored per bank; addr[AW-1:0] used, upper bits ignored.
- LAT, 4: cycles from grant to rdy; legal range 2..15.
- RFSH_CYC, 8: cycles one refresh occupies; legal range 1..255.
- rst  in  1  synchronous, active-high reset.
- clk  in  1  single clock for everything.
- refresh_en  in  1  refresh window; refreshes run while high.
- prog_addr  in  22  word address.
- prog_data  in  16  write data.
- prog_mask  in  2  byte mask; bit=1 leaves that byte unwritten ([1]=upper).
- prog_ba  in  2  target bank.
- prog_we, prog_rd  in  1  write / read request levels.
- prog_ack, prog_rdy  out  1  acceptance / completion pulses.
- ba0_addr  in  22; ba0_rd, ba0_wr  in  1; ba0_din  in  16; ba0_din_m  in  2 (same mask rule).
- ba0_ack, ba0_rdy  out  1.
- baN_addr  in  22; baN_rd  in  1; baN_ack, baN_rdy  out  1 (N=1..3).
- data_read  out  32  {word addr+1, word addr} of the bank last read.

## Operation
- Storage: four RAMs of 2^AW x 16, one per bank; contents undefined after power-up, not cleared by rst.
- Request protocol: requester raises rd/wr with stable addr/data and holds until its rdy. Grant at cycle t gives ack pulse at t+1 and rdy pulse at t+LAT. Requests lowered before grant are dropped silently.
- rd and wr both high on ba0 (or prog_we and prog_rd): treated as write.
- FSM states: IDLE, BUSY, RFSH.
- IDLE priority each cycle: prog request > refresh_en > bank requests in round-robin.
- Round-robin: pointer starts at bank 0 after reset; search begins at pointer; after a grant to bank k the pointer becomes k+1 mod 4.
- Grant: latch requester id, address, data, mask, direction; go BUSY, latency counter=LAT-1.
- BUSY: count down; at zero: write performs masked RAM write, read loads data_read with {mem[a+1], mem[a]}, a+1 wraps within AW bits; pulse the requester's rdy; back to IDLE.
- Hold-off: a port is ineligible in the cycle after its rdy, so a request lowered one cycle late is not re-served.
- Write completion leaves data_read unchanged.
- RFSH: entered from IDLE when refresh_en high and no prog request; counter RFSH_CYC-1 down to 0, no grants; returns to IDLE, a new refresh starts immediately if refresh_en still high and no prog request.
- refresh_en falling during RFSH does not cut the refresh short.
- refresh_en rising during BUSY: access completes first.

## Timing
- Reset values: all ack/rdy 0, data_read 0, state IDLE, pointer 0, counters 0.
- rst asserted mid-access: access abandoned, no rdy issued, RAM write not performed.
- All outputs registered; ack and rdy exactly one cycle wide.
- Back-to-back throughput: one access per LAT+1 cycles (grant cycle plus LAT).
- prog_ack/prog_rdy follow the same timing as bank ports.
- data_read valid from the rdy cycle until the next read rdy.

## Test plan
- Prog write bank 2 addr 5 = 16'hA55A, addr 6 = 16'h1234, mask 00; ba2_rd addr 5 -> ba2_ack at t+1, ba2_rdy at t+4, data_read = 32'h1234_A55A.
- Masked write: ba0_wr addr 0 din 16'hFFFF mask 00, then din 16'h0000 mask 10 -> read gives lower half 16'hFF00.
- All four baN_rd held from same cycle -> rdy order 0,1,2,3, spacing 5 cycles with LAT=4.
- refresh_en high 1 cycle with ba1_rd pending in IDLE -> ba1_ack delayed RFSH_CYC cycles. refresh_en rising during BUSY -> current rdy still arrives on time.
- Read addr 2^AW-1 -> upper half of data_read = word 0 (wrap).
- rst pulse during BUSY of a write -> no rdy, location keeps prior value, pointer 0 afterwards.

Source files
------------

// File: rtl/jtsdram_resp.sv
// jtsdram_resp: SDRAM controller stand-in for the JTSDRAM bank ports.
// Arbitrates a programming port and four bank ports, models access latency and refresh, serves block RAM.
module jtsdram_resp #(
    parameter int AW       = 10,
    parameter int LAT      = 4,
    parameter int RFSH_CYC = 8
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        refresh_en,
    input  logic [21:0] prog_addr,
    input  logic [15:0] prog_data,
    input  logic [1:0]  prog_mask,
    input  logic [1:0]  prog_ba,
    input  logic        prog_we,
    input  logic        prog_rd,
    output logic        prog_ack,
    output logic        prog_rdy,
    input  logic [21:0] ba0_addr,
    input  logic        ba0_rd,
    input  logic        ba0_wr,
    input  logic [15:0] ba0_din,
    input  logic [1:0]  ba0_din_m,
    output logic        ba0_ack,
    output logic        ba0_rdy,
    input  logic [21:0] ba1_addr,
    input  logic        ba1_rd,
    output logic        ba1_ack,
    output logic        ba1_rdy,
    input  logic [21:0] ba2_addr,
    input  logic        ba2_rd,
    output logic        ba2_ack,
    output logic        ba2_rdy,
    input  logic [21:0] ba3_addr,
    input  logic        ba3_rd,
    output logic        ba3_ack,
    output logic        ba3_rdy,
    output logic [31:0] data_read
);
    typedef enum logic [1:0] {IDLE, BUSY, RFSH} state_t;
    localparam logic [2:0] PROG_ID = 3'd4;

    state_t        state;
    logic [7:0]    cnt;
    logic [1:0]    ptr;
    logic [4:0]    ack_q;
    logic [4:0]    rdy_q;
    logic [2:0]    lat_id;
    logic [1:0]    lat_bank;
    logic [AW-1:0] lat_addr;
    logic [15:0]   lat_data;
    logic [1:0]    lat_mask;
    logic          lat_we;

    logic [15:0]   mem [4][2**AW];

    logic [AW-1:0] bank_addr [4];
    logic [3:0]    bank_req;
    logic          prog_req;
    logic          rr_hit;
    logic [1:0]    rr_id;
    logic          finish;
    logic [AW-1:0] addr_nxt;
    logic          unused_addr_bits;

    assign bank_addr[0] = ba0_addr[AW-1:0];
    assign bank_addr[1] = ba1_addr[AW-1:0];
    assign bank_addr[2] = ba2_addr[AW-1:0];
    assign bank_addr[3] = ba3_addr[AW-1:0];
    assign unused_addr_bits = ^{prog_addr[21:AW], ba0_addr[21:AW], ba1_addr[21:AW],
                                ba2_addr[21:AW], ba3_addr[21:AW]};

    // A port whose rdy is showing cannot be re-granted, so a one-cycle-late drop is harmless.
    assign prog_req = (prog_we | prog_rd) & ~rdy_q[4];
    assign bank_req = {ba3_rd, ba2_rd, ba1_rd, ba0_rd | ba0_wr} & ~rdy_q[3:0];
    assign finish   = (state == BUSY) && (cnt == 8'd0);
    assign addr_nxt = lat_addr + AW'(1);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rr_hit = 1'b0;
        rr_id  = ptr;
        for (int i = 0; i < 4; i++) begin
            if (!rr_hit && bank_req[ptr + 2'(i)]) begin
                rr_hit = 1'b1;
                rr_id  = ptr + 2'(i);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            ptr       <= 2'd0;
            ack_q     <= '0;
            rdy_q     <= '0;
            data_read <= 32'd0;
            lat_id    <= 3'd0;
            lat_bank  <= 2'd0;
            lat_addr  <= '0;
            lat_data  <= 16'd0;
            lat_mask  <= 2'd0;
            lat_we    <= 1'b0;
        end else begin
            ack_q <= '0;
            rdy_q <= '0;
            case (state)
                BUSY: begin
                    if (cnt == 8'(LAT - 1)) ack_q[lat_id] <= 1'b1;
                    if (cnt == 8'd0) begin
                        rdy_q[lat_id] <= 1'b1;
                        if (!lat_we)
                            data_read <= {mem[lat_bank][addr_nxt], mem[lat_bank][lat_addr]};
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    // The last refresh cycle arbitrates directly, so a refresh costs exactly RFSH_CYC cycles.
                    if (state == RFSH && cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (prog_req) begin
                        state    <= BUSY;
                        cnt      <= 8'(LAT - 1);
                        lat_id   <= PROG_ID;
                        lat_bank <= prog_ba;
                        lat_addr <= prog_addr[AW-1:0];
                        lat_data <= prog_data;
                        lat_mask <= prog_mask;
                        lat_we   <= prog_we;
                    end else if (refresh_en) begin
                        state <= RFSH;
                        cnt   <= 8'(RFSH_CYC - 1);
                    end else if (rr_hit) begin
                        state    <= BUSY;
                        cnt      <= 8'(LAT - 1);
                        ptr      <= rr_id + 2'd1;
                        lat_id   <= {1'b0, rr_id};
                        lat_bank <= rr_id;
                        lat_addr <= bank_addr[rr_id];
                        lat_data <= ba0_din;
                        lat_mask <= ba0_din_m;
                        lat_we   <= (rr_id == 2'd0) && ba0_wr;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // NOTE: the RAM has no reset; only the write enable is gated so an abandoned write never lands.
    always_ff @(posedge clk) begin
        if (!rst && finish && lat_we) begin
            if (!lat_mask[0]) mem[lat_bank][lat_addr][7:0]  <= lat_data[7:0];
            if (!lat_mask[1]) mem[lat_bank][lat_addr][15:8] <= lat_data[15:8];
        end
    end

    assign {prog_ack, ba3_ack, ba2_ack, ba1_ack, ba0_ack} = ack_q;
    assign {prog_rdy, ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy} = rdy_q;
endmodule

// File: tb/tb_jtsdram_resp.sv
// Directed self-checking bench for jtsdram_resp: latency, masking, wrap, refresh, arbitration, reset abort.
module tb_jtsdram_resp;
    localparam int AW       = 10;
    localparam int LAT      = 4;
    localparam int RFSH_CYC = 8;
    localparam int PROG     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        refresh_en = 1'b0;
    logic [21:0] prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic [1:0]  prog_mask = '0;
    logic [1:0]  prog_ba = '0;
    logic        prog_we = 1'b0;
    logic        prog_rd = 1'b0;
    logic        prog_ack, prog_rdy;
    logic [21:0] ba0_addr = '0;
    logic        ba0_rd = 1'b0;
    logic        ba0_wr = 1'b0;
    logic [15:0] ba0_din = '0;
    logic [1:0]  ba0_din_m = '0;
    logic        ba0_ack, ba0_rdy;
    logic [21:0] ba1_addr = '0;
    logic        ba1_rd = 1'b0;
    logic        ba1_ack, ba1_rdy;
    logic [21:0] ba2_addr = '0;
    logic        ba2_rd = 1'b0;
    logic        ba2_ack, ba2_rdy;
    logic [21:0] ba3_addr = '0;
    logic        ba3_rd = 1'b0;
    logic        ba3_ack, ba3_rdy;
    logic [31:0] data_read;

    logic [4:0]  ackv, rdyv;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    jtsdram_resp #(.AW(AW), .LAT(LAT), .RFSH_CYC(RFSH_CYC)) dut (
        .rst(rst), .clk(clk), .refresh_en(refresh_en),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask), .prog_ba(prog_ba),
        .prog_we(prog_we), .prog_rd(prog_rd), .prog_ack(prog_ack), .prog_rdy(prog_rdy),
        .ba0_addr(ba0_addr), .ba0_rd(ba0_rd), .ba0_wr(ba0_wr), .ba0_din(ba0_din),
        .ba0_din_m(ba0_din_m), .ba0_ack(ba0_ack), .ba0_rdy(ba0_rdy),
        .ba1_addr(ba1_addr), .ba1_rd(ba1_rd), .ba1_ack(ba1_ack), .ba1_rdy(ba1_rdy),
        .ba2_addr(ba2_addr), .ba2_rd(ba2_rd), .ba2_ack(ba2_ack), .ba2_rdy(ba2_rdy),
        .ba3_addr(ba3_addr), .ba3_rd(ba3_rd), .ba3_ack(ba3_ack), .ba3_rdy(ba3_rdy),
        .data_read(data_read)
    );

    assign ackv = {prog_ack, ba3_ack, ba2_ack, ba1_ack, ba0_ack};
    assign rdyv = {prog_rdy, ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Raise or drop one requester; 'both' drives rd together with wr.
    task automatic set_req(input int p, input logic on, input logic we, input logic both);
        case (p)
            0: begin ba0_wr = on & we; ba0_rd = on & (~we | both); end
            1: ba1_rd = on;
            2: ba2_rd = on;
            3: ba3_rd = on;
            default: begin prog_we = on & we; prog_rd = on & (~we | both); end
        endcase
    endtask

    // One access; request raised just after an edge, so edge 1 is the grant edge when nothing blocks.
    // The requester drops one cycle late; no ack/rdy may appear afterwards.
    task automatic xfer(input string tag, input int p, input logic we, input logic both,
                        input logic [21:0] addr, input logic [15:0] din, input logic [1:0] mask,
                        input logic [1:0] ba, input int rf_from, input int rf_to,
                        input int exp_ack, input int exp_rdy);
        int ack_k, rdy_k, n_ack, spurious;
        ack_k = -1; rdy_k = -1; n_ack = 0; spurious = 0;
        prog_addr = addr; ba0_addr = addr; ba1_addr = addr; ba2_addr = addr; ba3_addr = addr;
        prog_data = din;  ba0_din = din;   prog_mask = mask; ba0_din_m = mask; prog_ba = ba;
        set_req(p, 1'b1, we, both);
        for (int k = 1; k <= 60 && rdy_k < 0; k++) begin
            refresh_en = (k >= rf_from) && (k < rf_to);
            tick();
            if (ackv[p]) begin
                n_ack++;
                if (ack_k < 0) ack_k = k;
            end
            if (rdyv[p]) rdy_k = k;
        end
        refresh_en = 1'b0;
        tick();
        if (|{ackv, rdyv}) spurious++;
        set_req(p, 1'b0, 1'b0, 1'b0);
        repeat (LAT) begin
            tick();
            if (|{ackv, rdyv}) spurious++;
        end
        check($sformatf("%s ack cycle", tag), ack_k, exp_ack);
        check($sformatf("%s rdy cycle", tag), rdy_k, exp_rdy);
        check($sformatf("%s ack pulses", tag), n_ack, 1);
        check($sformatf("%s stray pulses", tag), spurious, 0);
    endtask

    initial begin
        int rk[4];
        int stray;

        rst = 1'b1;
        repeat (3) tick();
        check("reset ack/rdy", {22'd0, ackv, rdyv}, 32'd0);
        check("reset data_read", data_read, 32'd0);
        rst = 1'b0;

        // Programming writes, then bank read with wrapped word pair
        xfer("prog wr b2a5", PROG, 1, 0, 22'd5, 16'hA55A, 2'b00, 2'd2, 0, 0, 2, LAT + 1);
        xfer("prog wr b2a6", PROG, 1, 0, 22'd6, 16'h1234, 2'b00, 2'd2, 0, 0, 2, LAT + 1);
        check("write keeps data_read", data_read, 32'd0);
        xfer("ba2 rd a5", 2, 0, 0, 22'd5, 16'h0, 2'b00, 2'd0, 0, 0, 2, LAT + 1);
        check("ba2 rd a5 data", data_read, 32'h1234_A55A);

        // Byte-masked writes on bank 0
        xfer("ba0 wr a0", 0, 1, 0, 22'd0, 16'hFFFF, 2'b00, 2'd0, 0, 0, 2, LAT + 1);
        xfer("ba0 wr a1", 0, 1, 0, 22'd1, 16'h0BAD, 2'b00, 2'd0, 0, 0, 2, LAT + 1);
        xfer("ba0 wr a0 m10", 0, 1, 0, 22'd0, 16'h0000, 2'b10, 2'd0, 0, 0, 2, LAT + 1);
        xfer("ba0 rd a0", 0, 0, 0, 22'd0, 16'h0, 2'b00, 2'd0, 0, 0, 2, LAT + 1);
        check("masked data", data_read, 32'h0BAD_FF00);

        // rd+wr together counts as a write
        xfer("ba0 rdwr a1", 0, 1, 1, 22'd1, 16'hBEEF, 2'b00, 2'd0, 0, 0, 2, LAT + 1);
        check("rdwr keeps data_read", data_read, 32'h0BAD_FF00);
        xfer("ba0 rd a0 again", 0, 0, 0, 22'd0, 16'h0, 2'b00, 2'd0, 0, 0, 2, LAT + 1);
        check("rdwr data", data_read, 32'hBEEF_FF00);

        // Programming read wins over an active refresh window
        xfer("prog rd prio", PROG, 0, 0, 22'd5, 16'h0, 2'b00, 2'd2, 1, 1000, 2, LAT + 1);
        check("prog rd data", data_read, 32'h1234_A55A);

        // Top address wraps to word 0; upper address bits ignored
        xfer("prog wr b0top", PROG, 1, 0, 22'd1023, 16'h7777, 2'b00, 2'd0, 0, 0, 2, LAT + 1);
        xfer("ba0 rd top", 0, 0, 0, 22'h3FFFFF, 16'h0, 2'b00, 2'd0, 0, 0, 2, LAT + 1);
        check("wrap data", data_read, 32'hFF00_7777);

        // One-cycle refresh pulse delays a pending request by RFSH_CYC cycles
        xfer("ba1 rd rfsh", 1, 0, 0, 22'd0, 16'h0, 2'b00, 2'd0, 1, 2,
             2 + RFSH_CYC, 1 + RFSH_CYC + LAT);
        // Refresh rising mid-access leaves the access on time
        xfer("ba2 rd rfsh busy", 2, 0, 0, 22'd5, 16'h0, 2'b00, 2'd0, 3, 1000, 2, LAT + 1);
        check("rfsh busy data", data_read, 32'h1234_A55A);

        // Reset in the middle of a write abandons it
        xfer("prog wr b0a2", PROG, 1, 0, 22'd2, 16'h1111, 2'b00, 2'd0, 0, 0, 2, LAT + 1);
        xfer("prog wr b0a3", PROG, 1, 0, 22'd3, 16'h3333, 2'b00, 2'd0, 0, 0, 2, LAT + 1);
        ba0_addr = 22'd2; ba0_din = 16'h2222; ba0_din_m = 2'b00;
        set_req(0, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        check("abort ack seen", {31'd0, ba0_ack}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b0, 1'b0, 1'b0);
        check("rst clears outputs", {22'd0, ackv, rdyv}, 32'd0);
        check("rst clears data_read", data_read, 32'd0);
        stray = 0;
        repeat (2 * LAT) begin
            tick();
            if (|{ackv, rdyv}) stray++;
        end
        check("no rdy after abort", stray, 0);
        xfer("prog rd b0a2", PROG, 0, 0, 22'd2, 16'h0, 2'b00, 2'd0, 0, 0, 2, LAT + 1);
        check("aborted write data", data_read, 32'h3333_1111);

        // All four banks at once after reset: round-robin from bank 0
        ba0_addr = 22'd0; ba1_addr = 22'd0; ba2_addr = 22'd0; ba3_addr = 22'd0;
        for (int p = 0; p < 4; p++) begin
            rk[p] = -1;
            set_req(p, 1'b1, 1'b0, 1'b0);
        end
        for (int k = 1; k <= 60 && rk[3] < 0; k++) begin
            tick();
            for (int p = 0; p < 4; p++) begin
                if (rdyv[p] && rk[p] < 0) begin
                    rk[p] = k;
                    set_req(p, 1'b0, 1'b0, 1'b0);
                end
            end
        end
        for (int p = 0; p < 4; p++) set_req(p, 1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 4; p++)
            check($sformatf("rr rdy ba%0d", p), rk[p], (p + 1) * (LAT + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
